// File: rtl/demux1_3_registered_if.sv
// Handshake bundle for demux1_3_registered.
//   d_in/in_valid/in_ready/sel : producer side, one word routed by sel
//   outN/outN_valid/outN_ready : consumer side, one registered channel each
//   cntN                       : delivered-word counters (only with DEMUX_STATS_EN)
// Modports: slave = the demux, master = the environment driving/consuming it.
// Optional feature macro: DEMUX_STATS_EN.
interface demux1_3_registered_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] d_in;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;

  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             out0_valid;
  logic             out1_valid;
  logic             out2_valid;
  logic             out0_ready;
  logic             out1_ready;
  logic             out2_ready;

`ifdef DEMUX_STATS_EN
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;
  logic [7:0]       cnt2;
`endif

  modport slave (
    input  d_in, in_valid, sel, out0_ready, out1_ready, out2_ready,
    output in_ready, out0, out1, out2, out0_valid, out1_valid, out2_valid
`ifdef DEMUX_STATS_EN
    , output cnt0, cnt1, cnt2
`endif
  );

  modport master (
    output d_in, in_valid, sel, out0_ready, out1_ready, out2_ready,
    input  in_ready, out0, out1, out2, out0_valid, out1_valid, out2_valid
`ifdef DEMUX_STATS_EN
    , input cnt0, cnt1, cnt2
`endif
  );

endinterface

// File: rtl/demux1_3_registered.sv
// 1-to-3 registered demultiplexer with valid/ready handshakes.
// Each output channel is a one-entry buffer (EMPTY/FULL). A word on d_in is
// routed by sel (00->0, 01->1, 10/11->2) and appears on its channel one cycle
// after the input transfer. A full channel whose consumer is ready accepts a
// new word in the same cycle it drains, so a streaming channel has no bubbles.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; empties all channels, zeroes data
//   bus   : demux1_3_registered_if.slave (data, sel, handshakes, counters)
// Optional feature macro: DEMUX_STATS_EN adds 8-bit wrapping delivered-word
// counters cnt0..cnt2 (one increment per output transfer).
module demux1_3_registered #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  demux1_3_registered_if.slave  bus
);

  localparam int unsigned NumCh = 3;

  logic [1:0]       ch_idx;
  logic [NumCh-1:0] out_ready;
  logic [NumCh-1:0] out_xfer;
  logic [NumCh-1:0] in_xfer;
  logic             in_ready;

  logic [NumCh-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [NumCh];
  logic [WIDTH-1:0] data_d [NumCh];

  // sel=11 aliases channel 2
  assign ch_idx    = (bus.sel == 2'b11) ? 2'd2 : bus.sel;
  assign out_ready = {bus.out2_ready, bus.out1_ready, bus.out0_ready};

  // Gated by rst_n so nothing is offered as accepted while reset is held.
  assign in_ready     = rst_n & (~valid_q[ch_idx] | out_ready[ch_idx]);
  assign bus.in_ready = in_ready;

  always_comb begin
    out_xfer = '0;
    in_xfer  = '0;
    valid_d  = valid_q;
    for (int unsigned n = 0; n < NumCh; n++) begin
      data_d[n]   = data_q[n];
      out_xfer[n] = valid_q[n] & out_ready[n];
      in_xfer[n]  = bus.in_valid & in_ready & (32'(ch_idx) == n);
      // Load wins over drain: simultaneous transfer keeps the channel FULL.
      if (in_xfer[n]) begin
        valid_d[n] = 1'b1;
        data_d[n]  = bus.d_in;
      end else if (out_xfer[n]) begin
        valid_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned n = 0; n < NumCh; n++) begin
        data_q[n] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned n = 0; n < NumCh; n++) begin
        data_q[n] <= data_d[n];
      end
    end
  end

  assign bus.out0       = data_q[0];
  assign bus.out1       = data_q[1];
  assign bus.out2       = data_q[2];
  assign bus.out0_valid = valid_q[0];
  assign bus.out1_valid = valid_q[1];
  assign bus.out2_valid = valid_q[2];

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [NumCh];
  logic [7:0] cnt_d [NumCh];

  always_comb begin
    for (int unsigned n = 0; n < NumCh; n++) begin
      cnt_d[n] = cnt_q[n] + {7'd0, out_xfer[n]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NumCh; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NumCh; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
`endif

endmodule

// File: tb/tb_demux1_3_registered.sv
// Directed and scoreboarded random bench for demux1_3_registered.
module tb_demux1_3_registered;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;

  demux1_3_registered_if #(.WIDTH(WIDTH)) dif ();

  demux1_3_registered #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
    dif.in_valid = v;
    dif.sel      = s;
    dif.d_in     = d;
    #1;
  endtask

  task automatic set_ready(input logic r0, input logic r1, input logic r2);
    dif.out0_ready = r0;
    dif.out1_ready = r1;
    dif.out2_ready = r2;
    #1;
  endtask

  task automatic check_valids(input string tag, input logic [2:0] exp);
    check_eq(tag, {29'd0, dif.out2_valid, dif.out1_valid, dif.out0_valid}, {29'd0, exp});
  endtask

  // Random-phase reference model: one queue per channel.
  logic [7:0] sb [3][$];

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    dif.in_valid   = 1'b0;
    dif.sel        = 2'b00;
    dif.d_in       = 8'h00;
    dif.out0_ready = 1'b1;
    dif.out1_ready = 1'b1;
    dif.out2_ready = 1'b1;

    // Reset state, with a word offered
    drive(1'b1, 2'b00, 8'hEE);
    #1;
    check_valids("rst_valids", 3'b000);
    check_eq("rst_out0", {24'd0, dif.out0}, 32'h0);
    check_eq("rst_out2", {24'd0, dif.out2}, 32'h0);
    check_eq("rst_in_ready", {31'd0, dif.in_ready}, 32'h0);
    tick();
    check_valids("rst_hold_valids", 3'b000);
    drive(1'b0, 2'b00, 8'h00);
    rst_n = 1'b1;

    // Basic routing, all consumers ready
    drive(1'b1, 2'b00, 8'hA1);
    check_eq("rt_ready0", {31'd0, dif.in_ready}, 32'h1);
    tick();
    check_valids("rt_v_a1", 3'b001);
    check_eq("rt_out0", {24'd0, dif.out0}, 32'hA1);
    drive(1'b1, 2'b01, 8'hB2);
    tick();
    check_valids("rt_v_b2", 3'b010);
    check_eq("rt_out1", {24'd0, dif.out1}, 32'hB2);
    drive(1'b1, 2'b10, 8'hC3);
    tick();
    check_valids("rt_v_c3", 3'b100);
    check_eq("rt_out2_c3", {24'd0, dif.out2}, 32'hC3);
    drive(1'b1, 2'b11, 8'hD4);
    check_eq("rt_ready_full_drain", {31'd0, dif.in_ready}, 32'h1);
    tick();
    check_valids("rt_v_d4", 3'b100);
    check_eq("rt_out2_d4", {24'd0, dif.out2}, 32'hD4);
    drive(1'b0, 2'b00, 8'h00);
    tick();
    check_valids("rt_idle", 3'b000);
    check_eq("rt_out2_retain", {24'd0, dif.out2}, 32'hD4);

    // Backpressure on channel 1
    set_ready(1'b1, 1'b0, 1'b1);
    drive(1'b1, 2'b01, 8'h11);
    check_eq("bp_ready_first", {31'd0, dif.in_ready}, 32'h1);
    tick();
    check_eq("bp_out1_first", {24'd0, dif.out1}, 32'h11);
    drive(1'b1, 2'b01, 8'h22);
    check_eq("bp_ready_blocked", {31'd0, dif.in_ready}, 32'h0);
    tick();
    check_eq("bp_out1_held", {24'd0, dif.out1}, 32'h11);
    check_valids("bp_v_held", 3'b010);
    set_ready(1'b1, 1'b1, 1'b1);
    check_eq("bp_ready_release", {31'd0, dif.in_ready}, 32'h1);
    tick();
    check_eq("bp_out1_second", {24'd0, dif.out1}, 32'h22);
    check_valids("bp_v_second", 3'b010);
    drive(1'b0, 2'b00, 8'h00);
    tick();
    check_valids("bp_drained", 3'b000);

    // Independence: channel 0 stalled, channel 2 still accepts
    set_ready(1'b0, 1'b1, 1'b1);
    drive(1'b1, 2'b00, 8'h77);
    tick();
    check_eq("ind_out0", {24'd0, dif.out0}, 32'h77);
    drive(1'b1, 2'b10, 8'h55);
    check_eq("ind_ready2", {31'd0, dif.in_ready}, 32'h1);
    tick();
    check_eq("ind_out2", {24'd0, dif.out2}, 32'h55);
    check_eq("ind_out0_kept", {24'd0, dif.out0}, 32'h77);
    check_valids("ind_valids", 3'b101);
    drive(1'b1, 2'b00, 8'h66);
    check_eq("ind_ready0_blocked", {31'd0, dif.in_ready}, 32'h0);

    // Fill all channels, then async reset between edges
    set_ready(1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'b01, 8'h99);
    tick();
    check_valids("ar_all_full", 3'b111);
    drive(1'b1, 2'b01, 8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check_valids("ar_valids", 3'b000);
    check_eq("ar_out0", {24'd0, dif.out0}, 32'h0);
    check_eq("ar_out1", {24'd0, dif.out1}, 32'h0);
    check_eq("ar_out2", {24'd0, dif.out2}, 32'h0);
    check_eq("ar_in_ready", {31'd0, dif.in_ready}, 32'h0);
    tick();
    check_eq("ar_in_ready_edge", {31'd0, dif.in_ready}, 32'h0);
    check_valids("ar_valids_edge", 3'b000);
    drive(1'b0, 2'b00, 8'h00);
    rst_n = 1'b1;
    tick();
    check_valids("ar_discarded", 3'b000);
    drive(1'b1, 2'b00, 8'h44);
    tick();
    check_eq("ar_resume", {24'd0, dif.out0}, 32'h44);
    drive(1'b0, 2'b00, 8'h00);
    set_ready(1'b1, 1'b1, 1'b1);
    tick();

`ifdef DEMUX_STATS_EN
    rst_n = 1'b0;
    #1;
    check_eq("st_cnt1_rst", {24'd0, dif.cnt1}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 2'b01, i[7:0]);
      tick();
    end
    drive(1'b0, 2'b00, 8'h00);
    tick();
    check_eq("st_cnt0", {24'd0, dif.cnt0}, 32'h0);
    check_eq("st_cnt1", {24'd0, dif.cnt1}, 32'h1);
    check_eq("st_cnt2", {24'd0, dif.cnt2}, 32'h0);
`endif

    // Random traffic against a per-channel queue model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [2:0] rdy;
      logic [1:0] s;
      logic [7:0] d;
      logic       v;
      int         k;
      logic       exp_ready;
      rdy = 3'($urandom);
      s   = 2'($urandom);
      d   = 8'($urandom);
      v   = 1'($urandom);
      set_ready(rdy[0], rdy[1], rdy[2]);
      drive(v, s, d);
      k = (s == 2'b11) ? 2 : int'(s);
      exp_ready = (sb[k].size() == 0) || rdy[k];
      check_eq("rnd_in_ready", {31'd0, dif.in_ready}, {31'd0, exp_ready});
      check_valids("rnd_valids", {sb[2].size() != 0, sb[1].size() != 0, sb[0].size() != 0});
      if (sb[0].size() != 0) check_eq("rnd_out0", {24'd0, dif.out0}, {24'd0, sb[0][0]});
      if (sb[1].size() != 0) check_eq("rnd_out1", {24'd0, dif.out1}, {24'd0, sb[1][0]});
      if (sb[2].size() != 0) check_eq("rnd_out2", {24'd0, dif.out2}, {24'd0, sb[2][0]});
      for (int n = 0; n < 3; n++) begin
        if (sb[n].size() != 0 && rdy[n]) void'(sb[n].pop_front());
      end
      if (v && exp_ready) sb[k].push_back(d);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
